mbisr_chain_ctrl: RTL and testbench

- Sequencer for a serial chain of MBISR repair registers (concatenated per-memory shift registers).
- Load mode: streams repair words from a fuse or repair source into the chain.
- Readback mode: captures chain contents in parallel, then shifts them out as words for compare or fuse programming.
- Sits between the BISR fuse/JTAG controller and the chain's SI/SE/SO pins; owns the chain clock enable.

---
 rtl/mbisr_chain_ctrl_if.sv | 30 +++
 rtl/mbisr_chain_ctrl.sv | 113 +++++++++++
 tb/tb_mbisr_chain_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/mbisr_chain_ctrl_if.sv
// rtl/mbisr_chain_ctrl_if.sv - control, source, readback and chain pin bundle for the MBISR chain sequencer
interface mbisr_chain_ctrl_if #(
   parameter int WORD_W = 16
);
   logic              start;
   logic              mode;
   logic              abort;
   logic              src_valid;
   logic              src_ready;
   logic [WORD_W-1:0] src_data;
   logic              dst_valid;
   logic [WORD_W-1:0] dst_data;
   logic              chain_si;
   logic              chain_se;
   logic              chain_ce;
   logic              chain_so;
   logic              busy;
   logic              done;

   // master: fuse/JTAG controller plus chain SO pin; slave: the sequencer
   modport master (
      output start, mode, abort, src_valid, src_data, chain_so,
      input  src_ready, dst_valid, dst_data, chain_si, chain_se, chain_ce, busy, done
   );

   modport slave (
      input  start, mode, abort, src_valid, src_data, chain_so,
      output src_ready, dst_valid, dst_data, chain_si, chain_se, chain_ce, busy, done
   );
endinterface

// File: rtl/mbisr_chain_ctrl.sv
// rtl/mbisr_chain_ctrl.sv - sequencer that loads or reads back a serial MBISR repair chain
module mbisr_chain_ctrl #(
   parameter int CHAIN_LEN = 104,
   parameter int CNT_W     = 8,
   parameter int WORD_W    = 16
) (
   input  logic                  CLK,
   input  logic                  RSTB,
   mbisr_chain_ctrl_if.slave     bus
);
   localparam int FILL_W = $clog2(WORD_W + 1);
   localparam int PIDX_W = $clog2(WORD_W);

   typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_SHIFT, S_DONE} state_t;

   state_t              state_q;
   logic                mode_q;
   logic [CNT_W-1:0]    bit_cnt_q;
   logic [WORD_W-1:0]   buf_q;
   logic [FILL_W-1:0]   fill_q;
   logic                si_hold_q;
   logic [WORD_W-1:0]   pack_q;
   logic [PIDX_W-1:0]   pidx_q;
   logic                dst_valid_q;
   logic [WORD_W-1:0]   dst_data_q;

   logic                last_bit;
   logic                word_end;
   logic                buf_empty;
   logic [CNT_W-1:0]    remain;
   logic [FILL_W-1:0]   fill_d;
   logic [WORD_W-1:0]   pack_d;

   assign last_bit  = (bit_cnt_q == CNT_W'(CHAIN_LEN - 1));
   assign word_end  = (pidx_q == PIDX_W'(WORD_W - 1)) || last_bit;
   assign buf_empty = (fill_q == '0);
   // the last word only contributes the bits still missing from the chain
   assign remain    = CNT_W'(CHAIN_LEN) - bit_cnt_q;
   assign fill_d    = (remain >= CNT_W'(WORD_W)) ? FILL_W'(WORD_W) : remain[FILL_W-1:0];
   assign pack_d    = pack_q | ({{(WORD_W-1){1'b0}}, bus.chain_so} << pidx_q);

   assign bus.busy      = (state_q != S_IDLE);
   assign bus.done      = (state_q == S_DONE);
   assign bus.chain_se  = (state_q == S_SHIFT);
   assign bus.chain_ce  = (state_q == S_CAPTURE) || ((state_q == S_SHIFT) && (mode_q || !buf_empty));
   assign bus.src_ready = (state_q == S_SHIFT) && !mode_q && buf_empty && !bus.abort;
   // SI holds its last driven value across source stalls; readback pushes zeros
   assign bus.chain_si  = mode_q ? 1'b0 : (buf_empty ? si_hold_q : buf_q[0]);
   assign bus.dst_valid = dst_valid_q;
   assign bus.dst_data  = dst_data_q;

   always_ff @(posedge CLK or negedge RSTB) begin
      if (!RSTB) begin
         state_q     <= S_IDLE;
         mode_q      <= 1'b0;
         bit_cnt_q   <= '0;
         buf_q       <= '0;
         fill_q      <= '0;
         si_hold_q   <= 1'b0;
         pack_q      <= '0;
         pidx_q      <= '0;
         dst_valid_q <= 1'b0;
         dst_data_q  <= '0;
      end else begin
         dst_valid_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (bus.start && !bus.abort) begin
                  mode_q    <= bus.mode;
                  bit_cnt_q <= '0;
                  fill_q    <= '0;
                  buf_q     <= '0;
                  pack_q    <= '0;
                  pidx_q    <= '0;
                  state_q   <= bus.mode ? S_CAPTURE : S_SHIFT;
               end
            end
            S_CAPTURE: state_q <= bus.abort ? S_IDLE : S_SHIFT;
            S_SHIFT: begin
               if (bus.abort) begin
                  state_q <= S_IDLE;
                  fill_q  <= '0;
                  buf_q   <= '0;
                  pack_q  <= '0;
               end else if (mode_q) begin
                  bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                  if (word_end) begin
                     dst_valid_q <= 1'b1;
                     dst_data_q  <= pack_d;
                     pack_q      <= '0;
                     pidx_q      <= '0;
                  end else begin
                     pack_q <= pack_d;
                     pidx_q <= pidx_q + PIDX_W'(1);
                  end
                  if (last_bit) state_q <= S_DONE;
               end else if (!buf_empty) begin
                  buf_q     <= buf_q >> 1;
                  fill_q    <= fill_q - FILL_W'(1);
                  si_hold_q <= buf_q[0];
                  bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                  if (last_bit) state_q <= S_DONE;
               end else if (bus.src_valid) begin
                  buf_q  <= bus.src_data;
                  fill_q <= fill_d;
               end
            end
            S_DONE:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mbisr_chain_ctrl.sv
// tb/tb_mbisr_chain_ctrl.sv - self-checking bench for mbisr_chain_ctrl with a behavioural 104-bit chain
module tb_mbisr_chain_ctrl;
   logic CLK;
   logic RSTB;

   mbisr_chain_ctrl_if #(.WORD_W(16)) bif ();

   mbisr_chain_ctrl #(.CHAIN_LEN(104), .CNT_W(8), .WORD_W(16)) dut (
      .CLK  (CLK),
      .RSTB (RSTB),
      .bus  (bif)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // chain model: bit 0 sits at SO, SI enters at bit 103, SO retimed on negedge
   logic [103:0] chain_q;
   logic [103:0] chain_d;
   logic [103:0] preload_val;
   logic         preload_req;

   always @(posedge CLK) begin
      if (preload_req)
         chain_q <= preload_val;
      else if (bif.chain_ce)
         chain_q <= bif.chain_se ? {bif.chain_si, chain_q[103:1]} : chain_d;
   end

   always @(negedge CLK) bif.chain_so <= chain_q[0];

   typedef struct {
      logic        mode;
      logic [15:0] seed;
      int          gap_at;
      int          gap_len;
      logic        poke;
      int          exp_se;
      int          exp_ce;
   } vec_t;

   vec_t        tbl [5];
   int          n_chk;
   int          n_err;
   logic        exp_bits [$];
   logic [15:0] exp_words [$];

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   function automatic logic [15:0] word_of(input logic [15:0] s, input int k);
      return s ^ 16'(k * 40503) ^ 16'(k << 12);
   endfunction

   function automatic logic [22:0] outs();
      return {bif.busy, bif.done, bif.src_ready, bif.dst_valid, bif.dst_data,
              bif.chain_si, bif.chain_se, bif.chain_ce};
   endfunction

   task automatic run_op(input vec_t v, input int abort_at);
      int          k, gap, pushed, n_se, n_ce, n_before, n_done, se_drop;
      bit          aborted, valid;
      logic [15:0] w;
      logic [103:0] exp_chain;
      k = 0; pushed = 0; n_se = 0; n_ce = 0; n_done = 0; se_drop = 0; aborted = 0;
      gap = (v.gap_at == 0) ? v.gap_len : 0;
      exp_bits.delete();
      exp_words.delete();
      if (v.mode) begin
         chain_d = (v.seed == 16'h0) ? {13{8'hA5}}
                                     : 104'({$urandom(), $urandom(), $urandom(), $urandom()});
         for (int kw = 0; kw < 7; kw++) begin
            w = '0;
            for (int b = 0; b < 16; b++)
               if (16 * kw + b < 104) w[b] = chain_d[16 * kw + b];
            exp_words.push_back(w);
         end
      end
      @(negedge CLK);
      bif.start = 1'b1;
      bif.mode  = v.mode;
      @(negedge CLK);
      for (int cyc = 0; cyc < 1000; cyc++) begin
         bif.start = 1'b0;
         n_before  = n_ce;
         if (cyc == 0 && v.mode) chk("capture_cycle_se_ce", {bif.chain_se, bif.chain_ce}, 2'b01);
         if (bif.chain_se) n_se++;
         if (bif.chain_ce) n_ce++;
         if (!v.mode && bif.busy && !bif.done && !bif.chain_se) se_drop++;
         if (!v.mode && bif.chain_se && bif.chain_ce) begin
            if (exp_bits.size() == 0) chk("si_unexpected_shift", 1, 0);
            else chk("chain_si_bit", bif.chain_si, exp_bits.pop_front());
         end
         if (bif.dst_valid) begin
            if (exp_words.size() == 0) chk("dst_unexpected", 1, 0);
            else chk("dst_data", bif.dst_data, exp_words.pop_front());
         end
         if (bif.done) begin
            n_done++;
            break;
         end
         if (abort_at >= 0 && n_before == abort_at && !aborted) begin
            aborted = 1;
            bif.abort     = 1'b1;
            bif.src_valid = 1'b1;
            bif.src_data  = word_of(v.seed, k);
            #1 chk("abort_src_ready", bif.src_ready, 0);
            @(negedge CLK);
            bif.abort     = 1'b0;
            bif.src_valid = 1'b0;
            chk("abort_idle_outputs",
                {bif.busy, bif.done, bif.chain_se, bif.chain_ce, bif.src_ready, bif.dst_valid}, 0);
            repeat (3) begin
               @(negedge CLK);
               if (bif.done || bif.busy) n_done++;
            end
            break;
         end
         if (v.poke && cyc == 30) begin
            bif.start = 1'b1;
            bif.mode  = ~v.mode;
         end
         if (!v.mode) begin
            valid = (k < 7) && (gap == 0);
            bif.src_valid = valid;
            bif.src_data  = word_of(v.seed, k);
            #1;
            if (valid && bif.src_ready) begin
               w = word_of(v.seed, k);
               for (int b = 0; b < 16 && pushed < 104; b++) begin
                  exp_bits.push_back(w[b]);
                  pushed++;
               end
               k++;
               if (k == v.gap_at) gap = v.gap_len;
            end else if (!valid && bif.src_ready && gap > 0) begin
               gap--;
            end
         end
         @(negedge CLK);
      end
      bif.src_valid = 1'b0;
      bif.start     = 1'b0;
      if (aborted) begin
         chk("abort_no_done", n_done, 0);
      end else begin
         chk("done_count", n_done, 1);
         chk("se_cycles", n_se, v.exp_se);
         chk("ce_cycles", n_ce, v.exp_ce);
         if (v.poke) begin
            bif.start = 1'b1;
            bif.mode  = v.mode;
         end
         @(negedge CLK);
         bif.start = 1'b0;
         chk("idle_after_done", {bif.busy, bif.done}, 0);
         if (!v.mode) begin
            for (int i = 0; i < 104; i++) begin
               w = word_of(v.seed, i / 16);
               exp_chain[i] = w[i % 16];
            end
            chk("se_never_dropped", se_drop, 0);
            chk("si_bits_left", exp_bits.size(), 0);
            chk("chain_after_load", chain_q, exp_chain);
         end else begin
            chk("words_left", exp_words.size(), 0);
            chk("chain_zero_after_rb", chain_q, 0);
         end
      end
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;
      tbl[0] = '{1'b0, 16'h3C5A, -1, 0, 1'b0, 111, 104};
      tbl[1] = '{1'b0, 16'h3C5A,  3, 5, 1'b0, 116, 104};
      tbl[2] = '{1'b1, 16'h0000, -1, 0, 1'b0, 104, 105};
      tbl[3] = '{1'b0, 16'hF00D,  0, 2, 1'b1, 113, 104};
      tbl[4] = '{1'b1, 16'h1234, -1, 0, 1'b1, 104, 105};

      RSTB = 1'b0;
      bif.start = 1'b0; bif.mode = 1'b0; bif.abort = 1'b0;
      bif.src_valid = 1'b0; bif.src_data = '0;
      chain_d = '0;
      preload_val = 104'({$urandom(), $urandom(), $urandom(), $urandom()});
      preload_req = 1'b1;
      repeat (3) @(negedge CLK);
      preload_req = 1'b0;
      chk("reset_outputs", outs(), 0);
      RSTB = 1'b1;

      // asynchronous reset in the middle of a load
      @(negedge CLK);
      bif.start = 1'b1; bif.mode = 1'b0;
      @(negedge CLK);
      bif.start = 1'b0; bif.src_valid = 1'b1; bif.src_data = 16'hFFFF;
      repeat (6) @(negedge CLK);
      chk("busy_before_reset", {bif.busy, bif.chain_se, bif.chain_ce, bif.chain_si}, 4'b1111);
      #2 RSTB = 1'b0;
      #1 chk("async_reset_outputs", outs(), 0);
      bif.src_valid = 1'b0;
      @(negedge CLK);
      RSTB = 1'b1;
      @(negedge CLK);
      bif.start = 1'b1; bif.mode = 1'b0;
      @(negedge CLK);
      bif.start = 1'b0;
      chk("ready_first_shift", {bif.busy, bif.chain_se, bif.chain_ce, bif.src_ready}, 4'b1101);
      bif.abort = 1'b1;
      @(negedge CLK);
      bif.abort = 1'b0;
      chk("idle_after_cleanup_abort", bif.busy, 0);

      foreach (tbl[i]) run_op(tbl[i], -1);

      run_op(tbl[0], 40);
      run_op(tbl[3], 48);
      run_op(tbl[0], -1);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
